// File: rtl/aes_dec_ctrl.sv
// rtl/aes_dec_ctrl.sv - iterative AES-128 decryption sequencer, one inverse round per cycle
// Optional cached round-10 key (adds key_load port): define AES_DEC_KEYCACHE_EN.

module aes_dec_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0][7:0] din,
  input  logic [15:0][7:0] key_in,
`ifdef AES_DEC_KEYCACHE_EN
  input  logic             key_load,
`endif
  input  logic             dout_ack,
  output logic             ready,
  output logic [15:0][7:0] dout,
  output logic             dout_valid,
  output logic [3:0]       round
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // x^254 is the field inverse and conveniently maps 0 to 0, as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  // Byte k (FIPS order, k=0 is the most significant byte) sits at row k%4, column k/4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Undo one key-expansion step: round key rc in, round key rc-1 out
  function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] n0, n1, n2, n3, t;
    n3 = k[31:0]  ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    t  = {n3[23:0], n3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    n0 = k[127:96] ^ t ^ {rcon(rc), 24'h000000};
    return {n0, n1, n2, n3};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [127:0] dout_q, dout_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic         valid_q, valid_d;
  logic [127:0] din_w, acc_key;
  logic [127:0] r_out, keyout, fin_out;

  assign din_w = din;

  // invround datapath plus the final round, which skips InvMixColumns
  assign keyout  = inv_key(key_q, rcnt_q);
  assign r_out   = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ keyout);
  assign fin_out = inv_sub_bytes(inv_shift_rows(st_q)) ^ keyout;

`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] cache_q, cache_d;

  assign acc_key = key_load ? key_in : cache_q;
  assign cache_d = (state_q == S_IDLE && start && key_load) ? key_in : cache_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cache_q <= '0;
    else        cache_q <= cache_d;
  end
`else
  assign acc_key = key_in;
`endif

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    rcnt_d  = rcnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          st_d    = din_w ^ acc_key;
          key_d   = acc_key;
          rcnt_d  = 4'd10;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        st_d   = r_out;
        key_d  = keyout;
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q == 4'd2) state_d = S_FINAL;
      end
      S_FINAL: begin
        dout_d  = fin_out;
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (dout_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      key_q   <= '0;
      rcnt_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      rcnt_q  <= rcnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign round      = (state_q == S_ROUND || state_q == S_FINAL) ? rcnt_q : 4'd0;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb/tb_aes_dec_ctrl.sv - scoreboard bench for aes_dec_ctrl using a forward AES-128 reference
// Key-cache sequences are included when AES_DEC_KEYCACHE_EN is defined.

module tb_aes_dec_ctrl;

  typedef struct {
    logic [127:0] din;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  localparam int NV = 7;

  logic             clk;
  logic             rst_n;
  logic             start_r;
  logic [127:0]     din_r;
  logic [127:0]     key_r;
  logic             dout_ack_r;
  logic             ready;
  logic [15:0][7:0] dout;
  logic             dout_valid;
  logic [3:0]       round;
`ifdef AES_DEC_KEYCACHE_EN
  logic             key_load_r;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [127:0] sb_exp[$];
  int           sb_cyc[$];
  bit           v_seen = 1'b0;
  logic [127:0] mon_e;
  int           mon_c;

  logic [7:0] sbox_t [256];
  logic [7:0] rcon_t [11];
  vec_t       tbl [NV];

  aes_dec_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_r),
    .din        (din_r),
    .key_in     (key_r),
`ifdef AES_DEC_KEYCACHE_EN
    .key_load   (key_load_r),
`endif
    .dout_ack   (dout_ack_r),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .round      (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference model: forward cipher, S-box derived from log/antilog tables of generator 3
  function automatic logic [7:0] xt(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_tables();
    logic [7:0] exp_t [255];
    int         log_t [256];
    logic [7:0] p, inv, s, c;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = p;
      log_t[p] = i;
      p = p ^ xt(p);
    end
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
    rcon_t[0] = 8'h00;
    rcon_t[1] = 8'h01;
    for (int j = 2; j < 11; j++) rcon_t[j] = xt(rcon_t[j-1]);
  endtask

  function automatic logic [31:0] g(input logic [31:0] w, input int j);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_t[r[31:24]] ^ rcon_t[j], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k0, input int n);
    logic [31:0] w [44];
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) w[i] = w[i-4] ^ ((i % 4 == 0) ? g(w[i-1], i/4) : w[i-1]);
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] k0_from_k10(input logic [127:0] k10);
    logic [31:0] w [44];
    for (int i = 0; i < 4; i++) w[40+i] = k10[127-32*i -: 32];
    for (int i = 43; i >= 4; i--) w[i-4] = w[i] ^ ((i % 4 == 0) ? g(w[i-1], i/4) : w[i-1]);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k0);
    logic [127:0] s, t;
    logic [7:0] a0, a1, a2, a3;
    s = p ^ k0;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox_t[s[127-8*k -: 8]];
      t = s;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[127-8*(r+4*c) -: 8] = t[127-8*(r+4*((c+r)%4)) -: 8];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ round_key(k0, rnd);
    end
    return s;
  endfunction

  function automatic vec_t make_vec(input logic [127:0] p, input logic [127:0] k0);
    vec_t v;
    v.din = enc(p, k0);
    v.key = round_key(k0, 10);
    v.exp = p;
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: each rising dout_valid must match the oldest accepted block, 10 cycles after acceptance
  always @(negedge clk) begin
    if (!rst_n) begin
      v_seen = 1'b0;
    end else if (dout_valid && !v_seen) begin
      v_seen = 1'b1;
      if (sb_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected no result", dout);
      end else begin
        mon_e = sb_exp.pop_front();
        mon_c = sb_cyc.pop_front();
        chk("plaintext", dout, mon_e);
        chk("latency", cyc - mon_c, 10);
      end
    end else if (!dout_valid) begin
      v_seen = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input vec_t v);
    din_r   = v.din;
    key_r   = v.key;
    start_r = 1'b1;
    chk("ready_idle", ready, 1);
    sb_exp.push_back(v.exp);
    sb_cyc.push_back(cyc + 1);
    last_acc = cyc + 1;
    tick();
    start_r = 1'b0;
    chk("ready_busy", ready, 0);
    chk("round_first", round, 10);
  endtask

  task automatic follow_rounds();
    for (int r = 9; r >= 1; r--) begin
      tick();
      chk("round_seq", round, r);
      chk("valid_early", dout_valid, 0);
    end
    tick();
    chk("valid_rise", dout_valid, 1);
    chk("round_done", round, 0);
  endtask

  task automatic ack_block(input logic [127:0] e, input bit nxt, input vec_t nv);
    dout_ack_r = 1'b1;
    if (nxt) begin
      din_r   = nv.din;
      key_r   = nv.key;
      start_r = 1'b1;
    end
    tick();
    dout_ack_r = 1'b0;
    chk("valid_after_ack", dout_valid, 0);
    chk("ready_after_ack", ready, 1);
    chk("dout_kept_after_ack", dout, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vz, va, vb;
    int   prev;

    rst_n = 1'b0; start_r = 1'b0; dout_ack_r = 1'b0; din_r = '0; key_r = '0;
`ifdef AES_DEC_KEYCACHE_EN
    key_load_r = 1'b1;
`endif
    build_tables();

    tbl[0] = '{din: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               key: 128'h13111d7fe3944a17f307a78b4d2b30c5,
               exp: 128'h00112233445566778899aabbccddeeff};
    tbl[1] = make_vec(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    tbl[2] = make_vec('0, '0);
    tbl[3] = make_vec({128{1'b1}}, {128{1'b1}});
    for (int i = 4; i < NV; i++) tbl[i] = make_vec(rnd128(), rnd128());

    repeat (3) tick();
    chk("reset_ready", ready, 1);
    chk("reset_valid", dout_valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_round", round, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef AES_DEC_KEYCACHE_EN
    key_load_r = 1'b0;
    vz = make_vec(rnd128(), k0_from_k10('0));
    vz.key = rnd128();
    accept(vz);
    key_load_r = 1'b1;
    follow_rounds();
    ack_block(vz.exp, 1'b0, vz);
`endif

    // FIPS-197 C.1 with a delayed ack
    accept(tbl[0]);
    follow_rounds();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_dout", dout, tbl[0].exp);
      chk("hold_valid", dout_valid, 1);
    end
    ack_block(tbl[0].exp, 1'b0, tbl[0]);

    // start pulses while busy must be dropped
    accept(tbl[1]);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3 || i == 7) begin
        start_r = 1'b1;
        din_r   = ~tbl[1].din;
        chk("ready_low_busy", ready, 0);
      end
      tick();
      start_r = 1'b0;
    end
    chk("busy_valid", dout_valid, 1);
    ack_block(tbl[1].exp, 1'b0, tbl[1]);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_second_result", dout_valid, 0);
    end

    // asynchronous reset mid-operation
    accept(tbl[2]);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    sb_exp.delete();
    sb_cyc.delete();
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_valid", dout_valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_round", round, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    accept(tbl[2]);
    follow_rounds();
    ack_block(tbl[2].exp, 1'b0, tbl[2]);

    // back-to-back with same-cycle ack and restart
    for (int i = 3; i < NV; i++) begin
      prev = last_acc;
      accept(tbl[i]);
      if (i > 3) chk("throughput", last_acc - prev, 12);
      follow_rounds();
      ack_block(tbl[i].exp, i < NV - 1, tbl[(i < NV - 1) ? i + 1 : i]);
    end

`ifdef AES_DEC_KEYCACHE_EN
    va = make_vec(rnd128(), rnd128());
    key_load_r = 1'b1;
    accept(va);
    follow_rounds();
    ack_block(va.exp, 1'b0, va);
    vb = make_vec(rnd128(), k0_from_k10(va.key));
    vb.key = '0;
    key_load_r = 1'b0;
    accept(vb);
    key_load_r = 1'b1;
    follow_rounds();
    ack_block(vb.exp, 1'b0, vb);
`endif

    repeat (3) tick();
    chk("scoreboard_drained", sb_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
